// File: rtl/wt_reduce.sv
// Wallace-tree reducer for a 16-row partial-product array.
// One 3:2 compression stage is applied per clock (16->11->8->6->4->3->2 rows).
// A final exact 32-bit add of the last two rows produces P.
// The low APPROX_K columns may use a cheaper OR-based approximate compressor.
module wt_reduce #(
    parameter int APPROX_K = 0,
    parameter int ROWS     = 16,
    parameter int COLS     = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*COLS-1:0] WT_in,
    output logic [31:0]          P,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = 32;

    // Columns below APPROX_K use the approximate compressor.
    localparam logic [W-1:0] APPROX_MASK =
        (APPROX_K <= 0) ? '0 : ((W'(1) << APPROX_K) - W'(1));

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        ADD,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2:0]     stage;
    logic [W-1:0]   rows     [ROWS];
    logic [W-1:0]   rows_nxt [ROWS];
    int             trips;

    // Sum output of a row of 3:2 compressors, exact or approximate per column.
    function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        return ((a ^ b ^ c) & ~APPROX_MASK) | ((a | b | c) & APPROX_MASK);
    endfunction

    // Carry output, already shifted to the next column weight; bit 31 carry is dropped.
    function automatic logic [W-1:0] csa_carry(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] c);
        logic [W-1:0] maj;
        maj = ((a & b) | (a & c) | (b & c)) & ~APPROX_MASK;
        return maj << 1;
    endfunction

    // Control state register and stage counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stage <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                stage <= '0;
            else if (state == REDUCE)
                stage <= stage + 3'd1;
        end
    end

    // Next-state logic and the input handshake.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = REDUCE;
            end
            REDUCE: begin
                if (stage == 3'd5)
                    state_nxt = ADD;
            end
            ADD: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One Wallace stage: compress full triples, then move leftover rows down.
    // The row count per stage is fixed because the array always has 16 rows.
    always_comb begin
        for (int k = 0; k < ROWS; k++)
            rows_nxt[k] = '0;
        case (stage)
            3'd0:    trips = 5;
            3'd1:    trips = 3;
            3'd2:    trips = 2;
            3'd3:    trips = 2;
            3'd4:    trips = 1;
            3'd5:    trips = 1;
            default: trips = 0;
        endcase
        for (int i = 0; i < 5; i++) begin
            if (i < trips) begin
                rows_nxt[2*i]   = csa_sum(rows[3*i], rows[3*i+1], rows[3*i+2]);
                rows_nxt[2*i+1] = csa_carry(rows[3*i], rows[3*i+1], rows[3*i+2]);
            end
        end
        case (stage)
            3'd0: begin
                rows_nxt[10] = rows[15];
            end
            3'd1: begin
                rows_nxt[6] = rows[9];
                rows_nxt[7] = rows[10];
            end
            3'd2: begin
                rows_nxt[4] = rows[6];
                rows_nxt[5] = rows[7];
            end
            3'd4: begin
                rows_nxt[2] = rows[3];
            end
            default: begin
            end
        endcase
    end

    // Row registers, final add and output-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ROWS; k++)
                rows[k] <= '0;
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < ROWS; k++)
                            rows[k] <= W'(WT_in[k*COLS +: COLS]);
                    end
                end
                REDUCE: begin
                    for (int k = 0; k < ROWS; k++)
                        rows[k] <= rows_nxt[k];
                end
                ADD: begin
                    P         <= rows[0] + rows[1];
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
